// File: rtl/j101_wbck_arbiter_pkg.sv
// Types shared by the write-back arbiter, its output stage and its bus interface.
`include "j101_defines.v"

package j101_wbck_arbiter_pkg;

    localparam int XLEN    = `J101_XLEN;
    localparam int RFIDX_W = `J101_RFIDX_WIDTH;

    typedef logic [XLEN-1:0]    xlen_t;
    typedef logic [RFIDX_W-1:0] rfidx_t;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } gnt_e;

    // x0 is hard-wired to zero, so writes to it are dropped.
    function automatic logic is_x0(input rfidx_t idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/j101_wbck_arbiter_if.sv
// Write-back bus: two requesters (ALU, LSU) and the register-file write port.
interface j101_wbck_arbiter_if;
    import j101_wbck_arbiter_pkg::*;

    logic   alu_wbck_valid;
    logic   alu_wbck_ready;
    rfidx_t alu_wbck_idx;
    xlen_t  alu_wbck_dat;

    logic   lsu_wbck_valid;
    logic   lsu_wbck_ready;
    rfidx_t lsu_wbck_idx;
    xlen_t  lsu_wbck_dat;

    logic   rf_wbck_wen;
    rfidx_t rf_wbck_idx;
    xlen_t  rf_wbck_dat;

    // Arbiter side.
    modport slave (
        input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
        input  lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
        output alu_wbck_ready, lsu_wbck_ready,
        output rf_wbck_wen, rf_wbck_idx, rf_wbck_dat
    );

    // Requester / register-file side.
    modport master (
        output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
        output lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
        input  alu_wbck_ready, lsu_wbck_ready,
        input  rf_wbck_wen, rf_wbck_idx, rf_wbck_dat
    );

endinterface

// File: rtl/j101_defines.v
// Core-wide width definitions shared by the J101 pipeline.
`ifndef J101_DEFINES_V
`define J101_DEFINES_V
`define J101_XLEN        32
`define J101_RFIDX_WIDTH 5
`endif

// File: rtl/j101_wbck_stage.sv
// Single register stage between the arbiter and the register-file write port.
// idx/dat only load on a real write, so they hold their value while wen is low.
module j101_wbck_stage
    import j101_wbck_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hs_p0,
    input  rfidx_t idx_p0,
    input  xlen_t  dat_p0,
    output logic   wen_p1,
    output rfidx_t idx_p1,
    output xlen_t  dat_p1
);

    logic wr_p0;

    assign wr_p0 = hs_p0 && !is_x0(idx_p0);

    // Write enable pulses for exactly one cycle after each non-x0 handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_p1 <= 1'b0;
        end else begin
            wen_p1 <= wr_p0;
        end
    end

    // Capture index and data of the accepted write; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_p1 <= '0;
            dat_p1 <= '0;
        end else if (wr_p0) begin
            idx_p1 <= idx_p0;
            dat_p1 <= dat_p0;
        end
    end

endmodule

// File: rtl/j101_wbck_arbiter.sv
// Write-back arbiter: shares one register-file write port between ALU and LSU.
// LSU wins contention, except that an ALU denied STARVE_LIMIT cycles in a row
// is forced through on the next contended cycle.
module j101_wbck_arbiter
    import j101_wbck_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    j101_wbck_arbiter_if.slave  wb
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    gnt_e             gnt;
    logic             force_alu;
    logic             hs_p0;
    rfidx_t           idx_p0;
    xlen_t            dat_p0;

    assign force_alu = (starve_cnt == CNT_MAX);

    // Grant decision: purely from the valids and the starvation counter;
    // nothing is granted while reset is held.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (wb.alu_wbck_valid && (!wb.lsu_wbck_valid || force_alu)) begin
                gnt = GNT_ALU;
            end else if (wb.lsu_wbck_valid) begin
                gnt = GNT_LSU;
            end
        end
    end

    assign wb.alu_wbck_ready = (gnt == GNT_ALU);
    assign wb.lsu_wbck_ready = (gnt == GNT_LSU);

    // Select the granted requester's payload for the output stage.
    always_comb begin
        hs_p0  = (gnt != GNT_NONE);
        idx_p0 = wb.alu_wbck_idx;
        dat_p0 = wb.alu_wbck_dat;
        if (gnt == GNT_LSU) begin
            idx_p0 = wb.lsu_wbck_idx;
            dat_p0 = wb.lsu_wbck_dat;
        end
    end

    // Count consecutive cycles the ALU waits; saturate at the limit and clear
    // once the ALU gets through or withdraws its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (wb.alu_wbck_valid && (gnt != GNT_ALU)) begin
            if (!force_alu) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    j101_wbck_stage u_stage (
        .clk    (clk),
        .rst    (rst),
        .hs_p0  (hs_p0),
        .idx_p0 (idx_p0),
        .dat_p0 (dat_p0),
        .wen_p1 (wb.rf_wbck_wen),
        .idx_p1 (wb.rf_wbck_idx),
        .dat_p1 (wb.rf_wbck_dat)
    );

endmodule
